// File: rtl/lcd_pkg.sv
// Shared types and constants for the SPI LCD streamer.
// State encoding, DCS opcodes, ROM entry layout and window byte ordering.
package lcd_pkg;

    typedef enum logic [2:0] {
        RST_HOLD,
        RST_WAIT,
        INIT_FETCH,
        INIT_SEND,
        INIT_DELAY,
        IDLE,
        WIN_SEND,
        STREAM
    } lcd_state_t;

    localparam logic [7:0] DCS_CASET = 8'h2A;
    localparam logic [7:0] DCS_RASET = 8'h2B;
    localparam logic [7:0] DCS_RAMWR = 8'h2C;

    localparam int ROM_DELAY_BIT = 9;
    localparam int ROM_DC_BIT    = 8;
    localparam int ROM_ARG_MSB   = 7;

    localparam int WIN_BYTES = 11;

    typedef struct packed {
        logic [15:0] x0;
        logic [15:0] x1;
        logic [15:0] y0;
        logic [15:0] y1;
    } win_t;

    // Returns {dc, byte} for position idx of the CASET/RASET/RAMWR preamble.
    function automatic logic [8:0] win_byte(input logic [3:0] idx,
                                            input win_t w);
        logic [8:0] b;
        case (idx)
            4'd0:    b = {1'b0, DCS_CASET};
            4'd1:    b = {1'b1, w.x0[15:8]};
            4'd2:    b = {1'b1, w.x0[7:0]};
            4'd3:    b = {1'b1, w.x1[15:8]};
            4'd4:    b = {1'b1, w.x1[7:0]};
            4'd5:    b = {1'b0, DCS_RASET};
            4'd6:    b = {1'b1, w.y0[15:8]};
            4'd7:    b = {1'b1, w.y0[7:0]};
            4'd8:    b = {1'b1, w.y1[15:8]};
            4'd9:    b = {1'b1, w.y1[7:0]};
            4'd10:   b = {1'b0, DCS_RAMWR};
            default: b = {1'b1, 8'h00};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_spi_byte_tx.sv
// SPI mode-0 byte engine: one byte per load, MSB first, CS framed.
// Byte time is 18 SCLK half-periods: 16 for data, 2 with CS high.
module lcd_spi_byte_tx #(
    parameter int CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dc_in,
    input  logic [7:0] byte_in,
    output logic       done,
    output logic       busy,
    output logic       sclk,
    output logic       cs,
    output logic       dc,
    output logic       mosi
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [4:0] PH_LAST_BIT = 5'd15;
    localparam logic [4:0] PH_GAP      = 5'd16;
    localparam logic [4:0] PH_END      = 5'd17;

    logic [DW-1:0] div_cnt;
    logic [4:0]    ph;
    logic [7:0]    sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            busy    <= 1'b0;
            sclk    <= 1'b0;
            cs      <= 1'b1;
            dc      <= 1'b1;
            mosi    <= 1'b1;
            div_cnt <= '0;
            ph      <= '0;
            sh      <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (load) begin
                    busy    <= 1'b1;
                    cs      <= 1'b0;
                    dc      <= dc_in;
                    mosi    <= byte_in[7];
                    sh      <= byte_in;
                    sclk    <= 1'b0;
                    ph      <= '0;
                    div_cnt <= '0;
                end
            end else if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                ph      <= ph + 5'd1;
                // Even half-phases are SCLK low, odd ones SCLK high.
                case (ph)
                    PH_END: begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                    PH_GAP: ;
                    PH_LAST_BIT: begin
                        sclk <= 1'b0;
                        cs   <= 1'b1;
                        mosi <= 1'b1;
                    end
                    default: begin
                        if (ph[0]) begin
                            sclk <= 1'b0;
                            mosi <= sh[6];
                            sh   <= {sh[6:0], 1'b0};
                        end else begin
                            sclk <= 1'b1;
                        end
                    end
                endcase
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/lcd_spi_streamer.sv
// SPI LCD controller: panel reset, ROM-driven init with delays,
// per-frame CASET/RASET window and back-pressured pixel streaming.
module lcd_spi_streamer
    import lcd_pkg::*;
#(
    parameter int CLK_DIV         = 1,
    parameter int RESET_CYCLES    = 2700000,
    parameter int WAKE_CYCLES     = 5400000,
    parameter int NUM_CMDS        = 70,
    parameter int ADDR_W          = 7,
    parameter int DELAY_UNIT      = 27000,
    parameter int BYTES_PER_PIXEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [9:0]        rom_data,
    input  logic              frame_start,
    input  logic [15:0]       win_x0,
    input  logic [15:0]       win_x1,
    input  logic [15:0]       win_y0,
    input  logic [15:0]       win_y1,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              init_done,
    output logic              busy,
    output logic              frame_done,
    output logic              win_err,
    output logic              lcd_resetn,
    output logic              lcd_sclk,
    output logic              lcd_cs,
    output logic              lcd_dc,
    output logic              lcd_mosi
);

    lcd_state_t  state;
    logic [31:0] cnt;
    win_t        win;
    logic [3:0]  win_idx;
    logic        tx_wait;
    logic [33:0] rem;

    logic        tx_load;
    logic        tx_dc;
    logic [7:0]  tx_byte;
    logic        tx_done;
    logic        tx_busy;

    logic        win_ok;
    logic [31:0] delay_clks;
    logic [16:0] win_w;
    logic [16:0] win_h;
    logic [33:0] rem_calc;

    assign win_ok     = (win_x1 >= win_x0) && (win_y1 >= win_y0);
    assign delay_clks = 32'(rom_data[ROM_ARG_MSB:0]) * 32'(DELAY_UNIT);
    // Widths are 17 bits so a full 65536-wide span does not wrap.
    assign win_w    = {1'b0, win.x1} - {1'b0, win.x0} + 17'd1;
    assign win_h    = {1'b0, win.y1} - {1'b0, win.y0} + 17'd1;
    assign rem_calc = 34'(win_w) * 34'(win_h) * 34'(BYTES_PER_PIXEL);

    lcd_spi_byte_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .load    (tx_load),
        .dc_in   (tx_dc),
        .byte_in (tx_byte),
        .done    (tx_done),
        .busy    (tx_busy),
        .sclk    (lcd_sclk),
        .cs      (lcd_cs),
        .dc      (lcd_dc),
        .mosi    (lcd_mosi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RST_HOLD;
            cnt        <= '0;
            lcd_resetn <= 1'b0;
            rom_addr   <= '0;
            init_done  <= 1'b0;
            busy       <= 1'b1;
            frame_done <= 1'b0;
            win_err    <= 1'b0;
            s_ready    <= 1'b0;
            tx_load    <= 1'b0;
            tx_dc      <= 1'b1;
            tx_byte    <= '0;
            win        <= '0;
            win_idx    <= '0;
            tx_wait    <= 1'b0;
            rem        <= '0;
        end else begin
            tx_load    <= 1'b0;
            frame_done <= 1'b0;
            win_err    <= 1'b0;
            s_ready    <= 1'b0;
            unique case (state)
                RST_HOLD: begin
                    if (cnt == 32'(RESET_CYCLES - 1)) begin
                        cnt        <= '0;
                        lcd_resetn <= 1'b1;
                        state      <= RST_WAIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RST_WAIT: begin
                    if (cnt == 32'(WAKE_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= INIT_FETCH;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                INIT_FETCH: begin
                    if (rom_addr == ADDR_W'(NUM_CMDS)) begin
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (rom_data[ROM_DELAY_BIT]) begin
                        cnt   <= delay_clks;
                        state <= INIT_DELAY;
                    end else begin
                        tx_load <= 1'b1;
                        tx_dc   <= rom_data[ROM_DC_BIT];
                        tx_byte <= rom_data[ROM_ARG_MSB:0];
                        state   <= INIT_SEND;
                    end
                end
                INIT_SEND: begin
                    if (tx_done) begin
                        rom_addr <= rom_addr + 1'b1;
                        state    <= INIT_FETCH;
                    end
                end
                INIT_DELAY: begin
                    if (cnt == '0) begin
                        rom_addr <= rom_addr + 1'b1;
                        state    <= INIT_FETCH;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                IDLE: begin
                    if (frame_start) begin
                        if (win_ok) begin
                            win     <= {win_x0, win_x1, win_y0, win_y1};
                            win_idx <= '0;
                            tx_wait <= 1'b0;
                            busy    <= 1'b1;
                            state   <= WIN_SEND;
                        end else begin
                            win_err <= 1'b1;
                        end
                    end
                end
                WIN_SEND: begin
                    if (!tx_wait) begin
                        {tx_dc, tx_byte} <= win_byte(win_idx, win);
                        tx_load <= 1'b1;
                        tx_wait <= 1'b1;
                    end else if (tx_done) begin
                        tx_wait <= 1'b0;
                        if (win_idx == 4'(WIN_BYTES - 1)) begin
                            rem   <= rem_calc;
                            state <= STREAM;
                        end else begin
                            win_idx <= win_idx + 4'd1;
                        end
                    end
                end
                STREAM: begin
                    if (s_valid && s_ready) begin
                        tx_load <= 1'b1;
                        tx_dc   <= 1'b1;
                        tx_byte <= s_data;
                        rem     <= rem - 34'd1;
                    end else if (rem == '0) begin
                        if (tx_done) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                    end else begin
                        // Ready only once the engine is fully idle.
                        s_ready <= !tx_busy && !tx_load;
                    end
                end
                default: state <= RST_HOLD;
            endcase
        end
    end

endmodule
